// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the parity-mode constants, the receive FSM state encoding and the
// baud divisor helper. The future TX path uses the same package.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Receive FSM state encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_PUSH      = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
        int den;
        int div;
        den = baud_rate * oversample;
        div = (clk_freq + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with entry count and full/empty flags.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   wr_en, wr_data     push request and data
//   rd_en              pop request (head is already on rd_data)
//   rd_data            head entry, forced to 0 while empty
//   empty, full, count occupancy status (count is registered)
// Handshake: a push is taken when wr_en is high and the FIFO is not full,
// or when it is full and a pop happens in the same cycle; a pop is taken
// when rd_en is high and the FIFO is not empty. Refused requests are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Gate the head with empty so the output is a clean 0 after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with receive FIFO.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   rx_enable            receiver enable; low aborts a frame in progress
//   rx                   asynchronous serial input
//   rd_en                pop the FIFO head
//   clear_errors         clears the sticky overrun flag
//   rd_data, rd_parity_err, rd_framing_err   FIFO head (show-ahead)
//   fifo_empty, fifo_full, fifo_count        FIFO status
//   overrun              sticky: a frame was dropped on a full FIFO
//   rx_busy              FSM is outside IDLE
module uart_rx_param #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_enable,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clear_errors,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_parity_err,
    output logic                          rd_framing_err,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          rx_busy
);

    import uart_pkg::*;

    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int FW  = DATA_BITS + 2;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [SCW-1:0] HALF     = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] FULL     = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

    // Two-flop synchroniser plus a history flop for start-edge detection.
    logic rx_meta, rx_s, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev && !rx_s;

    // Free-running oversample tick; held in reset while disabled.
    logic [DCW-1:0] div_cnt;
    logic           tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                div_cnt <= '0;
        else if (!rx_enable)        div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
    end

    assign tick = rx_enable && (div_cnt == DIV_LAST);

    // Receive FSM.
    logic [2:0]           state;
    logic [SCW-1:0]       smp_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 push;

    // smp_cnt restarts at the mid-start sample, so every later sample
    // lands OVERSAMPLE ticks apart near the middle of each bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            smp_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else if (!rx_enable) begin
            state   <= ST_IDLE;
            smp_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state   <= ST_START;
                        smp_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (smp_cnt == HALF) begin
                            smp_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (smp_cnt == FULL) begin
                            smp_cnt <= '0;
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                stop_cnt <= 1'b0;
                                par_err  <= 1'b0;
                                frm_err  <= 1'b0;
                                state    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (smp_cnt == FULL) begin
                            smp_cnt <= '0;
                            par_err <= ((^shreg) ^ rx_s) != (PARITY_MODE == PARITY_ODD);
                            state   <= ST_STOP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (smp_cnt == FULL) begin
                            smp_cnt <= '0;
                            if (!rx_s) frm_err <= 1'b1;
                            if (STOP_BITS == 2 && !stop_cnt) stop_cnt <= 1'b1;
                            else                             state    <= ST_PUSH;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    // A framing error may be a break; wait for the line to
                    // return high before hunting for the next start edge.
                    state <= frm_err ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign push    = (state == ST_PUSH);
    assign rx_busy = (state != ST_IDLE);

    // Receive FIFO: each entry is {data, parity_err, framing_err}.
    logic [FW-1:0] fifo_rd;

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data ({shreg, par_err, frm_err}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign rd_data        = fifo_rd[FW-1:2];
    assign rd_parity_err  = fifo_rd[1];
    assign rd_framing_err = fifo_rd[0];

    // A new drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                        overrun <= 1'b0;
        else if (push && fifo_full && !rd_en) overrun <= 1'b1;
        else if (clear_errors)              overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    // 3.2 MHz / (50 kbaud * 16) = 4 clocks per tick, 64 clocks per bit.
    localparam int CLK_FREQ = 3200000;
    localparam int BAUD     = 50000;
    localparam int OS       = 16;
    localparam int DEPTH    = 8;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_enable;
    logic       rx;
    logic       rd_en;
    logic       clear_errors;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       rd_framing_err;
    logic       fifo_empty;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       rx_busy;

    uart_rx_param #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD),
        .DATA_BITS   (8),
        .PARITY_MODE (2),
        .STOP_BITS   (1),
        .OVERSAMPLE  (OS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .rx_enable      (rx_enable),
        .rx             (rx),
        .rd_en          (rd_en),
        .clear_errors   (clear_errors),
        .rd_data        (rd_data),
        .rd_parity_err  (rd_parity_err),
        .rd_framing_err (rd_framing_err),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .overrun        (overrun),
        .rx_busy        (rx_busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Scoreboard: expected FIFO contents {data, parity_err, framing_err}.
    logic [9:0] exp_q[$];
    logic       exp_ovr;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: one entry per completed frame; a full FIFO drops it.
    task automatic model_push(input logic [7:0] d, input logic pbit, input logic stop_v);
        logic [9:0] e;
        e = {d, (($countones(d) + int'(pbit)) % 2) != 0, stop_v == 1'b0};
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else                      exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
        check_eq({tag, ".empty"}, 32'(fifo_empty), 32'(exp_q.size() == 0));
        check_eq({tag, ".full"}, 32'(fifo_full), 32'(exp_q.size() == DEPTH));
        check_eq({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
        if (exp_q.size() != 0)
            check_eq({tag, ".head"}, 32'({rd_data, rd_parity_err, rd_framing_err}), 32'(exp_q[0]));
    endtask

    // Driver: start, 8 data bits LSB first, even parity (optionally wrong),
    // one stop bit, then an optional break of brk_bits low bits.
    task automatic send_frame(input logic [7:0] d, input logic flip_par,
                              input logic stop_v, input int brk_bits);
        logic pbit;
        pbit = (^d) ^ flip_par;
        rx = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLK);
        end
        rx = pbit;
        wait_clks(BIT_CLK);
        rx = stop_v;
        wait_clks(BIT_CLK);
        if (brk_bits > 0) begin
            rx = 1'b0;
            wait_clks(brk_bits * BIT_CLK);
            check_eq("break_busy", 32'(rx_busy), 32'd1);
        end
        rx = 1'b1;
        model_push(d, pbit, stop_v);
        wait_clks(8);
    endtask

    task automatic pop_one(input string tag);
        if (exp_q.size() != 0)
            check_eq({tag, ".head"}, 32'({rd_data, rd_parity_err, rd_framing_err}), 32'(exp_q[0]));
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
        if (exp_q.size() != 0) exp_q.delete(0);
        check_eq({tag, ".cnt"}, 32'(fifo_count), 32'(exp_q.size()));
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_one(tag);
    endtask

    initial begin
        logic [7:0] d;
        logic       flip;
        logic       stp;

        resetn       = 1'b0;
        rx_enable    = 1'b1;
        rx           = 1'b1;
        rd_en        = 1'b0;
        clear_errors = 1'b0;
        exp_ovr      = 1'b0;

        // Reset values.
        wait_clks(4);
        check_eq("rst.rd_data", 32'(rd_data), 32'd0);
        check_eq("rst.perr", 32'(rd_parity_err), 32'd0);
        check_eq("rst.ferr", 32'(rd_framing_err), 32'd0);
        check_eq("rst.busy", 32'(rx_busy), 32'd0);
        check_state("rst");
        resetn = 1'b1;
        wait_clks(4);

        // Basic frame, then pop to empty.
        send_frame(8'h55, 1'b0, 1'b1, 0);
        check_state("f55");
        pop_one("f55pop");
        check_eq("f55.empty", 32'(fifo_empty), 32'd1);

        // Parity: correct, then wrong parity bit.
        send_frame(8'hA3, 1'b0, 1'b1, 0);
        check_state("a3ok");
        pop_one("a3ok");
        send_frame(8'hA3, 1'b1, 1'b1, 0);
        check_state("a3bad");
        pop_one("a3bad");

        // Framing error followed by a 2-bit break, then a clean frame.
        send_frame(8'h3C, 1'b0, 1'b0, 2);
        check_eq("brk.idle", 32'(rx_busy), 32'd0);
        wait_clks(BIT_CLK);
        send_frame(8'h0F, 1'b0, 1'b1, 0);
        check_state("brk");
        drain("brk");

        // Short low glitch: start rejected, nothing pushed.
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(2);
        check_eq("glitch.busy", 32'(rx_busy), 32'd1);
        wait_clks(BIT_CLK / 2);
        check_eq("glitch.idle", 32'(rx_busy), 32'd0);
        check_state("glitch");

        // Overrun: nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        check_state("ovr");
        drain("ovr");
        check_eq("ovr.sticky", 32'(overrun), 32'd1);
        clear_errors = 1'b1;
        wait_clks(1);
        clear_errors = 1'b0;
        exp_ovr = 1'b0;
        check_state("ovrclr");

        // rx_enable dropped mid-frame: frame discarded, FIFO retained.
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        rx = 1'b0;
        wait_clks(3 * BIT_CLK);
        check_eq("abort.busy", 32'(rx_busy), 32'd1);
        rx_enable = 1'b0;
        wait_clks(1);
        check_eq("abort.idle", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        wait_clks(10 * BIT_CLK);
        rx_enable = 1'b1;
        wait_clks(BIT_CLK);
        check_state("abort");
        drain("abort");

        // rd_en while empty is ignored.
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
        check_state("emptypop");

        // Randomised traffic with random reads and occasional errors.
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 7) != 0);
            send_frame(d, flip, stp, 0);
            wait_clks($urandom_range(6, 24));
            check_state("rnd");
            if (exp_q.size() != 0 && $urandom_range(0, 2) != 0) pop_one("rndpop");
            if (exp_ovr && $urandom_range(0, 1) == 1) begin
                clear_errors = 1'b1;
                wait_clks(1);
                clear_errors = 1'b0;
                exp_ovr = 1'b0;
                check_state("rndclr");
            end
        end
        drain("rnddrain");

        // Reset during the data bits of a frame.
        send_frame(8'h11, 1'b0, 1'b1, 0);
        rx = 1'b0;
        wait_clks(BIT_CLK);
        rx = 1'b1;
        wait_clks(3 * BIT_CLK);
        check_eq("mid.busy", 32'(rx_busy), 32'd1);
        resetn = 1'b0;
        #1;
        exp_q.delete();
        exp_ovr = 1'b0;
        check_eq("mid.busy0", 32'(rx_busy), 32'd0);
        check_eq("mid.rd_data", 32'(rd_data), 32'd0);
        check_state("midrst");
        wait_clks(2);
        resetn = 1'b1;
        wait_clks(2 * BIT_CLK);
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        check_state("c3");
        drain("c3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
